// File: rtl/div_unit.sv
// Iterative 32-bit RV32M divider (DIV/DIVU/REM/REMU).
// Restoring division, one quotient bit per clock, using a single shared
// add_sub for the trial subtraction. Divide-by-zero and signed overflow
// complete in one cycle without iterating.

module add_sub (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_sub,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  logic [32:0] full_sum;
  logic [31:0] b_eff;

  // Subtraction is a + ~b + 1, so carry-out set means "no borrow" (a >= b).
  always_comb begin
    b_eff    = i_sub ? ~i_b : i_b;
    full_sum = {1'b0, i_a} + {1'b0, b_eff} + {32'd0, i_sub};
    o_sum    = full_sum[31:0];
    o_cout   = full_sum[32];
  end

endmodule

module div_unit (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_kill,
  output logic        o_ready,
  output logic        o_valid,
  output logic [31:0] o_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  // Latched operation context
  logic        rem_sel;
  logic        q_sign;
  logic        r_sign;
  logic [31:0] mag_b;

  // Iteration registers
  logic [31:0] rem_r;
  logic [31:0] quo_r;
  logic [4:0]  count;
  logic        steps_done;

  // Request decode
  logic        accept;
  logic        is_signed;
  logic        is_rem;
  logic        div_zero;
  logic        overflow;
  logic        fast_path;
  logic [31:0] mag_a;
  logic [31:0] mag_b_in;
  logic [31:0] fast_result;

  // One restoring step
  logic [32:0] shifted;
  logic [31:0] trial;
  logic        trial_cout;
  logic        success;
  logic [31:0] next_rem;
  logic [31:0] next_quo;
  logic [31:0] final_result;

  add_sub u_add_sub (
    .i_a    (shifted[31:0]),
    .i_b    (mag_b),
    .i_sub  (1'b1),
    .o_sum  (trial),
    .o_cout (trial_cout)
  );

  // Decode the incoming request and pick magnitudes and fast-path results.
  always_comb begin
    accept    = i_valid & (state == IDLE) & ~i_kill;
    is_signed = ~i_op[0];
    is_rem    = i_op[1];
    div_zero  = (i_b == 32'd0);
    overflow  = is_signed && (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
    fast_path = div_zero | overflow;
    mag_a     = (is_signed && i_a[31]) ? (32'd0 - i_a) : i_a;
    mag_b_in  = (is_signed && i_b[31]) ? (32'd0 - i_b) : i_b;
    if (div_zero) begin
      fast_result = is_rem ? i_a : 32'hFFFF_FFFF;
    end else begin
      fast_result = is_rem ? 32'd0 : 32'h8000_0000;
    end
  end

  // Trial subtraction and the shifted partial remainder/quotient for one step.
  always_comb begin
    shifted  = {rem_r, quo_r[31]};
    success  = shifted[32] | trial_cout;
    next_rem = success ? trial : shifted[31:0];
    next_quo = {quo_r[30:0], success};
    if (rem_sel) begin
      final_result = r_sign ? (32'd0 - rem_r) : rem_r;
    end else begin
      final_result = q_sign ? (32'd0 - quo_r) : quo_r;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_next = state;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (accept) begin
          state_next = fast_path ? DONE : CALC;
        end
      end
      CALC: begin
        if (i_kill) begin
          state_next = IDLE;
        end else if (steps_done) begin
          state_next = DONE;
        end
      end
      DONE: begin
        o_valid    = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: latch operands on accept, iterate in CALC, load the result on entering DONE.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rem_sel    <= 1'b0;
      q_sign     <= 1'b0;
      r_sign     <= 1'b0;
      mag_b      <= 32'd0;
      rem_r      <= 32'd0;
      quo_r      <= 32'd0;
      count      <= 5'd0;
      steps_done <= 1'b0;
      o_result   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rem_sel    <= is_rem;
            q_sign     <= is_signed & (i_a[31] ^ i_b[31]);
            r_sign     <= is_signed & i_a[31];
            mag_b      <= mag_b_in;
            rem_r      <= 32'd0;
            quo_r      <= mag_a;
            count      <= 5'd31;
            steps_done <= 1'b0;
            if (fast_path) begin
              o_result <= fast_result;
            end
          end
        end
        CALC: begin
          if (!i_kill) begin
            if (!steps_done) begin
              rem_r <= next_rem;
              quo_r <= next_quo;
              if (count == 5'd0) begin
                steps_done <= 1'b1;
              end else begin
                count <= count - 5'd1;
              end
            end else begin
              o_result <= final_result;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: table of directed vectors plus
// hand-written kill, reset and back-to-back sequences.

module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        valid;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        kill;
  logic        ready;
  logic        out_valid;
  logic [31:0] result;

  int errors;
  int checks;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  div_unit dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_valid  (valid),
    .i_op     (op),
    .i_a      (a),
    .i_b      (b),
    .i_kill   (kill),
    .o_ready  (ready),
    .o_valid  (out_valid),
    .o_result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and measure edges from the accept edge until o_valid.
  task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] res, output int lat);
    int w;
    w = 0;
    while (!ready && w < 100) begin
      step();
      w++;
    end
    check_output("ready_before_req", {31'd0, ready}, 32'd1);
    valid = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    step();
    valid = 1'b0;
    lat   = 0;
    while (!out_valid && lat < 60) begin
      step();
      lat++;
    end
    res = result;
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    int          saw_valid;
    int          pulses;
    int          first_at;
    int          second_at;
    logic [31:0] prev;

    errors = 0;
    checks = 0;
    reset  = 1'b1;
    valid  = 1'b0;
    kill   = 1'b0;
    op     = 2'b00;
    a      = 32'd0;
    b      = 32'd0;

    vecs[0]  = '{"divu_100_7",     OP_DIVU, 32'd100,        32'd7,          32'd14,         33};
    vecs[1]  = '{"remu_100_7",     OP_REMU, 32'd100,        32'd7,          32'd2,          33};
    vecs[2]  = '{"divu_max_1",     OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
    vecs[3]  = '{"div_m7_2",       OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
    vecs[4]  = '{"rem_m7_2",       OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
    vecs[5]  = '{"div_7_m2",       OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33};
    vecs[6]  = '{"rem_7_m2",       OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          33};
    vecs[7]  = '{"div_m8_m2",      OP_DIV,  32'hFFFF_FFF8,  32'hFFFF_FFFE,  32'd4,          33};
    vecs[8]  = '{"div_0_5",        OP_DIV,  32'd0,          32'd5,          32'd0,          33};
    vecs[9]  = '{"divu_5_0",       OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  0};
    vecs[10] = '{"rem_min_0",      OP_REM,  32'h8000_0000,  32'd0,          32'h8000_0000,  0};
    vecs[11] = '{"div_ovf",        OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0};
    vecs[12] = '{"rem_ovf",        OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0};
    vecs[13] = '{"divu_ovf_ops",   OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
    vecs[14] = '{"remu_1000_7",    OP_REMU, 32'd1000,       32'd7,          32'd6,          33};
    vecs[15] = '{"remu_ovf_ops",   OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33};

    // Reset state
    step();
    step();
    check_output("reset_ready",  {31'd0, ready},     32'd1);
    check_output("reset_valid",  {31'd0, out_valid}, 32'd0);
    check_output("reset_result", result,             32'd0);
    reset = 1'b0;
    step();

    // Directed vectors
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check_output({vecs[i].name, "_result"}, res, vecs[i].exp);
      check_output({vecs[i].name, "_latency"}, lat, vecs[i].lat);
      step();
      check_output({vecs[i].name, "_pulse_end"}, {31'd0, out_valid}, 32'd0);
      check_output({vecs[i].name, "_ready_after"}, {31'd0, ready}, 32'd1);
    end
    prev = 32'h8000_0000;

    // Kill on the 10th CALC cycle
    valid = 1'b1;
    op    = OP_DIVU;
    a     = 32'd1000;
    b     = 32'd3;
    step();
    valid = 1'b0;
    saw_valid = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (out_valid) saw_valid = 1;
    end
    kill = 1'b1;
    step();
    kill = 1'b0;
    if (out_valid) saw_valid = 1;
    check_output("kill_ready",  {31'd0, ready}, 32'd1);
    check_output("kill_result", result, prev);
    step();
    if (out_valid) saw_valid = 1;
    check_output("kill_no_pulse", saw_valid, 32'd0);
    apply_stimulus(OP_DIVU, 32'd50, 32'd5, res, lat);
    check_output("after_kill_result",  res, 32'd10);
    check_output("after_kill_latency", lat, 32'd33);
    step();

    // Kill together with valid in IDLE blocks acceptance
    valid = 1'b1;
    kill  = 1'b1;
    op    = OP_DIVU;
    a     = 32'd9;
    b     = 32'd0;
    step();
    check_output("idle_kill_ready", {31'd0, ready}, 32'd1);
    valid = 1'b0;
    kill  = 1'b0;
    step();
    check_output("idle_kill_no_pulse", {31'd0, out_valid}, 32'd0);
    check_output("idle_kill_result", result, 32'd10);

    // Reset on the 20th CALC cycle, valid held during reset
    valid = 1'b1;
    op    = OP_DIV;
    a     = 32'd1000;
    b     = 32'd7;
    step();
    valid = 1'b0;
    saw_valid = 0;
    for (int i = 0; i < 19; i++) begin
      step();
      if (out_valid) saw_valid = 1;
    end
    reset = 1'b1;
    valid = 1'b1;
    op    = OP_DIVU;
    a     = 32'd9;
    b     = 32'd3;
    step();
    check_output("midreset_ready",  {31'd0, ready}, 32'd1);
    check_output("midreset_valid",  {31'd0, out_valid}, 32'd0);
    check_output("midreset_result", result, 32'd0);
    step();
    step();
    check_output("reset_hold_ready", {31'd0, ready}, 32'd1);
    reset = 1'b0;
    valid = 1'b0;
    step();
    if (out_valid) saw_valid = 1;
    check_output("midreset_no_pulse", saw_valid, 32'd0);
    check_output("post_reset_ready", {31'd0, ready}, 32'd1);
    apply_stimulus(OP_DIV, 32'hFFFF_FC18, 32'd7, res, lat);
    check_output("post_reset_div", res, 32'hFFFF_FF72);
    step();
    apply_stimulus(OP_REM, 32'hFFFF_FC18, 32'd7, res, lat);
    check_output("post_reset_rem", res, 32'hFFFF_FFFA);
    step();

    // Back-to-back with valid held high: one accept per 35 cycles
    valid     = 1'b1;
    op        = OP_DIVU;
    a         = 32'd20;
    b         = 32'd4;
    pulses    = 0;
    first_at  = -1;
    second_at = -1;
    for (int n = 0; n < 75; n++) begin
      step();
      if (out_valid) begin
        pulses++;
        if (pulses == 1) first_at = n;
        if (pulses == 2) second_at = n;
        check_output("b2b_result", result, 32'd5);
      end
    end
    valid = 1'b0;
    check_output("b2b_pulses", pulses, 32'd2);
    check_output("b2b_first",  first_at, 32'd33);
    check_output("b2b_second", second_at, 32'd68);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions, sitting beside the ALU in the execute stage. It performs one restoring-division step per clock, built on a single `add_sub` instance used for the trial subtraction. The pipeline stalls execute while `o_ready` is low and picks up the result on `o_valid`. Divide-by-zero and signed overflow bypass the iteration and complete in one cycle.

## Interface
- No parameters; datapath fixed at 32 bits.
- `i_clk` in 1: clock; all state updates on rising edge.
- `i_reset` in 1: synchronous, active-high reset.
- `i_valid` in 1: request; sampled only when `o_ready`=1.
- `i_op` in 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `i_a` in 32: dividend.
- `i_b` in 32: divisor.
- `i_kill` in 1: abort in-flight op (pipeline flush).
- `o_ready` in/out: out 1: high only in IDLE; request accepted on edge where `i_valid & o_ready & ~i_kill`.
- `o_valid` out 1: one-cycle pulse, result available.
- `o_result` out 32: quotient or remainder; registered, held until next completion.

## Operation
- **States:** IDLE, CALC, DONE.
- **IDLE → CALC** on accept (normal case). Latch:
  - the op;
  - |a| and |b| (two's-complement magnitude when signed op and MSB=1, else raw);
  - quotient sign = `a[31]^b[31]` (signed only);
  - remainder sign = `a[31]` (signed only).
  - Clear partial remainder R; load quotient/shift register Q = |a|; iteration counter = 31.
- **IDLE → DONE** on accept when b==0. Result:
  - DIV/DIVU → 0xFFFFFFFF;
  - REM/REMU → `i_a` unmodified.
- **IDLE → DONE** on accept when DIV/REM with a==0x80000000 and b==0xFFFFFFFF. Result:
  - DIV → 0x80000000;
  - REM → 0.
- **CALC step**, one per edge:
  - shifted = {R[31:0], Q[31]} (33 bits);
  - trial = shifted[31:0] − |b| via `add_sub` (`i_sub`=1);
  - subtract succeeds when shifted[32]=1 or `o_cout`=1;
  - on success R ← trial, else R ← shifted[31:0];
  - Q ← {Q[30:0], success};
  - counter decrements.
- **CALC → DONE** on the edge after the step taken with counter==0 (32 steps total). On that edge `o_result` is loaded with Q (quotient) or R (remainder), negated if the corresponding latched sign is 1.
- **DONE → IDLE** unconditionally on next edge. `o_valid`=1 exactly while in DONE.
- **`i_kill`:**
  - in CALC: → IDLE next edge, no `o_valid`, `o_result` unchanged;
  - in IDLE: blocks acceptance;
  - in DONE: no effect (pulse still issued).
- **Requests** while `o_ready`=0 are ignored and are not queued.
- **Rounding:** quotient truncates toward zero; remainder takes the dividend's sign (RISC-V semantics).

## Timing
- **Reset:** any edge with `i_reset`=1 → IDLE, `o_ready`=1, `o_valid`=0, `o_result`=0, counter=0. This overrides `i_kill` and `i_valid`, and applies mid-CALC or in DONE (a pending pulse is dropped).
- **Normal op:** accept at edge E0; 32 steps at E1..E32; result registered and state=DONE at E33. `o_valid` is high in the cycle after E33 and `o_ready` rises after E34. Accept-to-result latency is 33 cycles; request-to-request throughput is 35 cycles.
- **Fast path (b==0 or overflow):** DONE at E0, `o_valid` in the cycle after E0, IDLE at E1.
- **`o_ready`** is a pure state decode and does not depend combinationally on `i_valid`.
- **`o_result`** changes only on the edge entering DONE, or on reset.

## Test plan
- **Unsigned:** DIVU a=100, b=7 → `o_result`=14, `o_valid` exactly 33 cycles after accept. REMU same operands → 2. DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF.
- **Signed:**
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF;
  - DIV 7/−2 → 0xFFFFFFFD; REM 7/−2 → 1;
  - DIV −8/−2 → 4.
- **Divide by zero:** DIVU 5/0 → 0xFFFFFFFF; REM 0x80000000/0 → 0x80000000. Both pulse `o_valid` one cycle after accept.
- **Overflow:** DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0; 1-cycle latency. DIVU with the same operands → 0 after 33 cycles.
- **Kill:**
  - `i_kill` on the 10th CALC cycle → no `o_valid`, `o_ready`=1 next cycle, `o_result` keeps the prior value;
  - a following DIVU 50/5 returns 10;
  - `i_kill`+`i_valid` in IDLE → not accepted.
- **Reset:**
  - `i_reset` on the 20th CALC cycle → IDLE, `o_result`=0, no pulse;
  - `i_valid` held high during reset is not accepted;
  - a post-reset op completes correctly;
  - back-to-back ops with `i_valid` held high are accepted only when `o_ready`=1.
